cp0_unit: RTL and testbench
===========================

# cp0_unit

Coprocessor-0 exception controller at the memory stage. It evaluates hardware interrupts and the exception code carried by the instruction in M. It drives the single-cycle `Req` request that flushes the M/W pipeline register and redirects fetch. It holds the SR, Cause, EPC and PRId registers used by `mfc0`, `mtc0` and `eret`.

## Interface
- `PRID`, default 32'h0000_4C50, constant value returned for register 15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while 0.
- `PCM`  in  32  PC of the instruction currently in M.
- `BDIn`  in  1  M instruction sits in a branch delay slot.
- `ExcCodeIn`  in  5  exception code of the M instruction; 0 = none.
- `HWInt`  in  6  level-sensitive hardware interrupt lines.
- `en`  in  1  `mtc0` write enable.
- `CP0Add`  in  5  register select for read and write.
- `CP0In`  in  32  `mtc0` write data.
- `EXLClr`  in  1  `eret` in M.
- `CP0Out`  out  32  `mfc0` read data.
- `EPCOut`  out  32  current EPC register, return target for `eret`.
- `Req`  out  1  exception/interrupt request; flushes pipeline registers and loads the handler PC.

## Operation
**Register map**
- SR (12): IM = bits [15:10], EXL = bit [1], IE = bit [0]. Other bits are read as 0 and ignore writes.
- Cause (13): BD = bit 31, IP = bits [15:10], ExcCode = bits [6:2]. Other bits read 0. Not writable by `mtc0`.
- EPC (14): 32-bit; bits [1:0] are always stored as 0.
- PRId (15): returns `PRID`. Read-only.
- Any other `CP0Add` reads 0; writes to it are ignored.

**Request logic** (combinational from current state and inputs)
- IntReq = IE & ~EXL & |(HWInt & IM).
- ExcReq = ~EXL & (ExcCodeIn != 0).
- Req = IntReq | ExcReq.
- Req is forced to 0 while reset = 0.

**On a clock edge with Req = 1**
- EXL <= 1.
- BD <= BDIn.
- ExcCode <= 0 if IntReq, otherwise ExcCodeIn. Interrupt has priority over a simultaneous exception.
- EPC <= (BDIn ? PCM - 4 : PCM) with bits [1:0] cleared. Subtraction is 32-bit modulo; wrap-around is allowed.
- `mtc0` in the same cycle is suppressed, because the instruction is cancelled.

**`eret`**
- With Req = 0 and EXLClr = 1: EXL <= 0 on the edge.
- With Req = 1 and EXLClr = 1: Req wins, so EXL is 1 after the edge.

**`mtc0`** (en = 1, Req = 0)
- Writes the selected writable register on the edge.
- If EXLClr is also set and SR is targeted, the clear from EXLClr overrides the written EXL value.

**Other behaviour**
- IP <= HWInt on every edge, independent of Req.
- `CP0Out` is a combinational read of the registered values. Same-cycle write data is not forwarded.
- `EPCOut` = EPC register.

## Timing
- Reset (async, reset = 0):
  - SR = 0, Cause = 0, EPC = 0.
  - Req = 0, CP0Out reflects the cleared registers, EPCOut = 0.
- Req asserts in the same cycle as its cause; zero latency.
- Req is high for one cycle per event, because EXL masks further requests from the next cycle on.
- Register updates become visible on CP0Out and EPCOut from the cycle after the edge.
- A level interrupt held through the handler re-requests one cycle after `eret` clears EXL, provided IE and IM still enable it.
- Reset asserted mid-handler clears EXL immediately; no request until reset = 1 and a new cause is present.

## Test plan
- Reset release with ExcCodeIn = 5'd4 held during reset: Req = 0 while reset = 0. After release, Req = 1 in the first cycle; next cycle Cause = 32'h0000_0010 and EXL = 1.
- mtc0 SR = 32'h0000_0401, HWInt = 6'b000001, PCM = 32'h0000_3010: Req = 1 one cycle after the write. Then EPC = 32'h0000_3010, ExcCode = 0, SR reads 32'h0000_0403.
- Exception in delay slot, ExcCodeIn = 5'd12, BDIn = 1, PCM = 32'h0000_3024: Req = 1 for exactly one cycle. Then EPC = 32'h0000_3020, Cause = 32'h8000_0030.
- Simultaneous enabled interrupt and ExcCodeIn = 5'd10: ExcCode = 0, Req pulse of 1 cycle, EXL = 1.
- EXL = 1 with ExcCodeIn = 5'd4 and HWInt active: Req stays 0. EXLClr pulse: EXL = 0 next cycle, and Req re-asserts that same cycle.
- mtc0 to EPC with CP0In = 32'h0000_3007: EPC reads 32'h0000_3004. mtc0 to Cause: Cause unchanged. mfc0 of register 15 returns PRID.

Source files
------------

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - coprocessor-0 exception controller (SR/Cause/EPC/PRId, request logic)
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_4C50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCM,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  // EPC, low two bits always zero
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_epc_target;

  // The cancelled instruction in M is the return point; in a delay slot we go back to the branch.
  assign w_int_req    = r_ie & ~r_exl & (|(HWInt & r_im));
  assign w_exc_req    = ~r_exl & (ExcCodeIn != 5'd0);
  assign w_req        = reset & (w_int_req | w_exc_req);
  assign w_wr_sr      = en & ~w_req & (CP0Add == ADDR_SR);
  assign w_wr_epc     = en & ~w_req & (CP0Add == ADDR_EPC);
  assign w_epc_target = BDIn ? (PCM - 32'd4) : PCM;

  assign Req    = w_req;
  assign EPCOut = r_epc;

  // SR update: exception entry sets EXL, eret clears it (overriding an mtc0 to SR), mtc0 loads IM/EXL/IE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= 6'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
    end else if (w_req) begin
      r_exl <= 1'b1;
    end else begin
      if (w_wr_sr) begin
        r_im <= CP0In[15:10];
        r_ie <= CP0In[0];
      end
      if (EXLClr) begin
        r_exl <= 1'b0;
      end else if (w_wr_sr) begin
        r_exl <= CP0In[1];
      end
    end
  end

  // Cause update: IP tracks the interrupt lines every cycle, BD/ExcCode latch on request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_bd      <= BDIn;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
      end
    end
  end

  // EPC update: request captures the return PC, otherwise mtc0 may load it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_epc <= 32'd0;
    end else if (w_req) begin
      r_epc <= {w_epc_target[31:2], 2'b00};
    end else if (w_wr_epc) begin
      r_epc <= {CP0In[31:2], 2'b00};
    end
  end

  // mfc0 read mux over registered state; unmapped addresses read zero
  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      ADDR_SR:    CP0Out = {16'd0, r_im, 8'd0, r_exl, r_ie};
      ADDR_CAUSE: CP0Out = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};
      ADDR_EPC:   CP0Out = r_epc;
      ADDR_PRID:  CP0Out = PRID;
      default:    CP0Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - self-checking bench for cp0_unit with a word-level reference model
module tb_cp0_unit;

  localparam logic [31:0] PRID_V   = 32'h0000_4C50;
  localparam logic [31:0] SR_MASK  = 32'h0000_FC03;
  localparam logic [31:0] IP_MASK  = 32'h0000_FC00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCM;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state held as whole architectural register words
  logic [31:0] m_sr, m_cause, m_epc;

  always #5 clk = ~clk;

  cp0_unit #(.PRID(PRID_V)) dut (
    .clk(clk), .reset(reset), .PCM(PCM), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .EXLClr(EXLClr),
    .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic m_exl();
    return (m_sr & 32'd2) != 0;
  endfunction

  function automatic logic m_intreq();
    logic [31:0] pending;
    pending = ({26'd0, HWInt} << 10) & m_sr & IP_MASK;
    return ((m_sr & 32'd1) != 0) && !m_exl() && (pending != 0);
  endfunction

  function automatic logic m_req();
    return reset && (m_intreq() || (!m_exl() && ExcCodeIn != 5'd0));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_clear();
    m_sr = 0; m_cause = 0; m_epc = 0;
  endtask

  task automatic m_edge();
    logic ir, rq;
    if (!reset) begin
      m_clear();
      return;
    end
    ir = m_intreq();
    rq = m_req();
    if (rq) begin
      m_sr    = m_sr | 32'd2;
      m_cause = (BDIn ? 32'h8000_0000 : 32'd0) | (ir ? 32'd0 : ({27'd0, ExcCodeIn} * 4));
      m_epc   = (BDIn ? PCM - 32'd4 : PCM) & ~32'd3;
    end else begin
      if (en && CP0Add == 5'd12) m_sr = CP0In & SR_MASK;
      if (en && CP0Add == 5'd14) m_epc = CP0In & ~32'd3;
      if (EXLClr) m_sr = m_sr & ~32'd2;
    end
    m_cause = (m_cause & ~IP_MASK) | ({26'd0, HWInt} << 10);
  endtask

  // compare all outputs at the falling edge, then advance the model on the rising edge
  task automatic tick();
    @(negedge clk);
    if (!reset) m_clear();
    check("req", {31'd0, Req}, {31'd0, m_req()});
    check("cp0out", CP0Out, m_read(CP0Add));
    check("epcout", EPCOut, m_epc);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] exp);
    #1;
    check(tag, CP0Out, exp);
  endtask

  task automatic peek_req(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, Req}, {31'd0, exp});
  endtask

  task automatic set_in(input logic [31:0] pcm, input logic bd, input logic [4:0] exc,
                        input logic [5:0] hw, input logic e, input logic [4:0] a,
                        input logic [31:0] d, input logic clr);
    PCM = pcm; BDIn = bd; ExcCodeIn = exc; HWInt = hw;
    en = e; CP0Add = a; CP0In = d; EXLClr = clr;
  endtask

  initial begin
    reset = 1'b0;
    m_clear();
    set_in(32'h0, 1'b0, 5'd4, 6'd0, 1'b0, 5'd13, 32'h0, 1'b0);
    peek_req("rst_req", 1'b0);
    tick();
    tick();

    // reset release with pending exception code
    reset = 1'b1;
    peek_req("rel_req", 1'b1);
    tick();
    ExcCodeIn = 5'd0;
    peek("rel_cause", 32'h0000_0010);
    CP0Add = 5'd12;
    peek("rel_exl", 32'h0000_0002);
    tick();
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // enabled interrupt after mtc0 SR
    set_in(32'h0000_3010, 1'b0, 5'd0, 6'b000001, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
    peek_req("int_pre", 1'b0);
    tick();
    en = 1'b0;
    CP0Add = 5'd14;
    peek_req("int_req", 1'b1);
    tick();
    peek("int_epc", 32'h0000_3010);
    CP0Add = 5'd13;
    peek("int_cause", 32'h0000_0400);
    CP0Add = 5'd12;
    peek("int_sr", 32'h0000_0403);
    tick();
    set_in(32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 5'd12, 32'h0, 1'b1);
    tick();

    // exception in a delay slot
    set_in(32'h0000_3024, 1'b1, 5'd12, 6'd0, 1'b0, 5'd14, 32'h0, 1'b0);
    peek_req("ds_req", 1'b1);
    tick();
    peek_req("ds_once", 1'b0);
    peek("ds_epc", 32'h0000_3020);
    CP0Add = 5'd13;
    peek("ds_cause", 32'h8000_0030);
    tick();
    set_in(32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 5'd12, 32'h0000_0801, 1'b1);
    tick();

    // simultaneous interrupt and exception: interrupt wins
    set_in(32'h0000_3100, 1'b0, 5'd10, 6'b000010, 1'b0, 5'd13, 32'h0, 1'b0);
    peek_req("sim_req", 1'b1);
    tick();
    peek_req("sim_once", 1'b0);
    peek("sim_cause", 32'h0000_0800);
    CP0Add = 5'd12;
    peek("sim_sr", 32'h0000_0803);
    ExcCodeIn = 5'd4;
    peek_req("exl_mask", 1'b0);
    tick();
    ExcCodeIn = 5'd0;
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    peek_req("reint_req", 1'b1);
    tick();

    // reset mid-handler
    reset = 1'b0;
    peek_req("mid_rst_req", 1'b0);
    peek("mid_rst_sr", 32'h0);
    m_clear();
    tick();
    reset = 1'b1;
    HWInt = 6'd0;
    peek_req("post_rst_req", 1'b0);
    tick();

    // mtc0 to EPC, Cause; PRId and unmapped reads
    set_in(32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 5'd14, 32'h0000_3007, 1'b0);
    tick();
    en = 1'b0;
    peek("epc_wr", 32'h0000_3004);
    set_in(32'h0, 1'b0, 5'd0, 6'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0);
    tick();
    en = 1'b0;
    peek("cause_ro", 32'h0);
    CP0Add = 5'd15;
    peek("prid", PRID_V);
    CP0Add = 5'd7;
    peek("unmapped", 32'h0);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [4:0] a;
      case ($urandom_range(0, 4))
        0: a = 5'd12;
        1: a = 5'd13;
        2: a = 5'd14;
        3: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      set_in($urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
             6'($urandom), ($urandom_range(0, 3) == 0), a, $urandom,
             ($urandom_range(0, 4) == 0));
      reset = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
